// File: rtl/lfsr_uart_tx.sv
// Captures one LFSR word per advance strobe and sends it as 8N1 UART frames,
// least significant byte first. Tracks completed words and a sticky wrap flag.
module lfsr_uart_tx #(
   parameter int NUM_BITS     = 32,
   parameter int CLKS_PER_BIT = 104
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_Run,
   input  logic [NUM_BITS-1:0] i_LFSR_Data,
   input  logic                i_LFSR_Done,
   output logic                o_LFSR_Enable,
   output logic                o_UART_TX,
   output logic                o_Busy,
   output logic                o_Wrap,
   output logic [15:0]         o_Word_Count
);

   localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam int              NUM_BYTES = NUM_BITS / 8;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [1:0]      BYTE_LAST = 2'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [1:0]          byte_q, byte_d;
   logic [NUM_BITS-1:0] word_q, word_d;
   logic                tx_q, tx_d;
   logic                enable_q, enable_d;
   logic                busy_q, busy_d;
   logic                wrap_q, wrap_d;
   logic [15:0]         word_count_q, word_count_d;
   logic                baud_done;
   logic [7:0]          sel_byte;

   assign baud_done = (baud_q == BAUD_LAST);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      byte_d       = byte_q;
      word_d       = word_q;
      wrap_d       = wrap_q;
      word_count_d = word_count_q;

      case (state_q)
         S_IDLE: begin
            if (i_Run) state_d = S_LOAD;
         end
         S_LOAD: begin
            word_d  = i_LFSR_Data;
            byte_d  = 2'd0;
            bit_d   = 3'd0;
            baud_d  = '0;
            if (i_LFSR_Done) wrap_d = 1'b1;
            state_d = S_START;
         end
         S_START: begin
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_d = '0;
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_done) begin
               baud_d = '0;
               if (byte_q < BYTE_LAST) begin
                  byte_d  = byte_q + 2'd1;
                  state_d = S_START;
               end else begin
                  word_count_d = word_count_q + 16'd1;
                  state_d      = i_Run ? S_LOAD : S_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are derived from the next state so they can be registered without lag.
      sel_byte = word_q[7:0];
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (byte_d == 2'(i)) sel_byte = word_q[8*i +: 8];
      end

      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = sel_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
      enable_d = (state_d == S_LOAD);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_q        <= 3'd0;
         byte_q       <= 2'd0;
         tx_q         <= 1'b1;
         enable_q     <= 1'b0;
         busy_q       <= 1'b0;
         wrap_q       <= 1'b0;
         word_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         tx_q         <= tx_d;
         enable_q     <= enable_d;
         busy_q       <= busy_d;
         wrap_q       <= wrap_d;
         word_count_q <= word_count_d;
      end
   end

   // NOTE: the word holding register is always loaded in LOAD before it is shifted out, so it carries no reset.
   always_ff @(posedge i_Clk) begin
      word_q <= word_d;
   end

   assign o_UART_TX     = tx_q;
   assign o_LFSR_Enable = enable_q;
   assign o_Busy        = busy_q;
   assign o_Wrap        = wrap_q;
   assign o_Word_Count  = word_count_q;

endmodule

// File: tb/tb_lfsr_uart_tx.sv
// Directed bench for lfsr_uart_tx with NUM_BITS=16, CLKS_PER_BIT=4, fed by a
// small 16-bit LFSR; outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_lfsr_uart_tx;

   localparam int NB  = 16;
   localparam int CPB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          done_drv;
   logic [NB-1:0] lfsr_q;
   logic          lfsr_load;
   logic [NB-1:0] lfsr_load_val;
   logic          en;
   logic          tx;
   logic          busy;
   logic          wrap;
   logic [15:0]   wcnt;

   int checks      = 0;
   int failures    = 0;
   int en_pulses   = 0;

   lfsr_uart_tx #(
      .NUM_BITS     (NB),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_Run         (run),
      .i_LFSR_Data   (lfsr_q),
      .i_LFSR_Done   (done_drv),
      .o_LFSR_Enable (en),
      .o_UART_TX     (tx),
      .o_Busy        (busy),
      .o_Wrap        (wrap),
      .o_Word_Count  (wcnt)
   );

   always #5 clk = ~clk;

   // x^16 + x^15 + x^13 + x^4 + 1, XNOR feedback shifted into bit 0
   always @(posedge clk) begin
      if (lfsr_load)
         lfsr_q <= lfsr_load_val;
      else if (en)
         lfsr_q <= {lfsr_q[14:0], ~(lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3])};
   end

   always @(negedge clk) begin
      if (en) en_pulses <= en_pulses + 1;
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic preload(input logic [NB-1:0] val);
      lfsr_load_val = val;
      lfsr_load     = 1'b1;
      tick(1);
      lfsr_load     = 1'b0;
   endtask

   task automatic wait_enable(input string tag);
      int k;
      for (k = 0; k < 200 && en !== 1'b1; k++) @(negedge clk);
      check({tag, "_enable_seen"}, 96'(en), 96'(1));
   endtask

   // Called on the LOAD-cycle sample; collects 80 bit-cycle samples of one word.
   task automatic capture_word(input string tag, input int drop_at,
                               output logic [15:0] w, output logic [79:0] raw);
      logic [3:0] frame;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         raw[i] = tx;
         if (i == drop_at) run = 1'b0;
      end
      for (int j = 0; j < 8; j++) begin
         w[j]     = raw[4*(1+j)+2];
         w[8+j]   = raw[4*(11+j)+2];
      end
      frame = {raw[2], raw[4*9+2], raw[4*10+2], raw[4*19+2]};
      check({tag, "_framing"}, 96'(frame), 96'(4'b0101));
   endtask

   initial begin
      logic [15:0] w;
      logic [79:0] raw;
      logic [79:0] exp80;
      int          p0;
      int          pat [20] = '{0, 0,1,0,1,1,0,1,0, 1, 0, 1,0,1,0,0,1,0,1, 1};

      rst       = 1'b1;
      run       = 1'b0;
      done_drv  = 1'b0;
      lfsr_load = 1'b0;
      lfsr_load_val = '0;
      tick(3);
      check("reset_tx",     96'(tx),   96'(1));
      check("reset_enable", 96'(en),   96'(0));
      check("reset_busy",   96'(busy), 96'(0));
      check("reset_wrap",   96'(wrap), 96'(0));
      check("reset_count",  96'(wcnt), 96'(0));
      run = 1'b1;
      tick(2);
      check("reset_run_ignored", 96'({en, busy}), 96'(0));
      run = 1'b0;
      rst = 1'b0;
      tick(2);

      // Single word 0xA55A, i_Run pulsed for one cycle
      preload(16'hA55A);
      p0  = en_pulses;
      run = 1'b1;
      wait_enable("single");
      run = 1'b0;
      capture_word("single", -1, w, raw);
      for (int i = 0; i < 80; i++) exp80[i] = (pat[i/4] != 0);
      check("single_tx_stream",   96'(raw), 96'(exp80));
      check("single_word",        96'(w),   96'(16'hA55A));
      check("single_busy_laststop", 96'(busy), 96'(1));
      check("single_count_before",  96'(wcnt), 96'(0));
      tick(1);
      check("single_count", 96'(wcnt), 96'(1));
      check("single_busy",  96'(busy), 96'(0));
      check("single_tx_idle", 96'(tx), 96'(1));
      check("single_pulses", 96'(en_pulses - p0), 96'(1));

      // Back-to-back words from seed 0xACE1: ACE1, 59C2, B385
      preload(16'hACE1);
      p0  = en_pulses;
      run = 1'b1;
      wait_enable("b2b");
      capture_word("b2b_w1", -1, w, raw);
      check("b2b_word1", 96'(w), 96'(16'hACE1));
      tick(1);
      check("b2b_load2_no_gap", 96'(en), 96'(1));
      check("b2b_count_after1", 96'(wcnt), 96'(2));
      capture_word("b2b_w2", -1, w, raw);
      check("b2b_word2", 96'(w), 96'(16'h59C2));
      tick(1);
      check("b2b_load3_no_gap", 96'(en), 96'(1));
      run = 1'b0;
      capture_word("b2b_w3", -1, w, raw);
      check("b2b_word3", 96'(w), 96'(16'hB385));
      tick(1);
      check("b2b_idle_busy", 96'(busy), 96'(0));
      check("b2b_count", 96'(wcnt), 96'(4));
      check("b2b_pulses", 96'(en_pulses - p0), 96'(3));

      // i_Run dropped during byte 0 data: word still completes
      preload(16'h3C96);
      p0  = en_pulses;
      run = 1'b1;
      wait_enable("drop");
      capture_word("drop", 10, w, raw);
      check("drop_word", 96'(w), 96'(16'h3C96));
      tick(1);
      check("drop_busy",  96'(busy), 96'(0));
      check("drop_count", 96'(wcnt), 96'(5));
      tick(8);
      check("drop_tx_idle", 96'(tx), 96'(1));
      check("drop_pulses", 96'(en_pulses - p0), 96'(1));

      // Wrap flag: Done outside LOAD ignored, Done in second LOAD sets it
      preload(16'h0F0F);
      run = 1'b1;
      wait_enable("wrap");
      tick(20);
      done_drv = 1'b1;
      tick(1);
      done_drv = 1'b0;
      tick(59);
      check("wrap_outside_load", 96'(wrap), 96'(0));
      tick(1);
      check("wrap_load2", 96'(en), 96'(1));
      done_drv = 1'b1;
      run      = 1'b0;
      tick(1);
      done_drv = 1'b0;
      check("wrap_set", 96'(wrap), 96'(1));
      tick(80);
      check("wrap_count", 96'(wcnt), 96'(7));
      check("wrap_sticky", 96'(wrap), 96'(1));

      // Reset during bit 3 of byte 1 (0x12 bit 3 = 0)
      preload(16'h1234);
      run = 1'b1;
      wait_enable("rst");
      tick(58);
      check("rst_pre_tx", 96'(tx), 96'(0));
      rst = 1'b1;
      tick(1);
      check("rst_tx",    96'(tx),   96'(1));
      check("rst_busy",  96'(busy), 96'(0));
      check("rst_count", 96'(wcnt), 96'(0));
      check("rst_wrap",  96'(wrap), 96'(0));
      tick(2);
      check("rst_run_held_ignored", 96'(en), 96'(0));
      rst = 1'b0;
      tick(1);
      check("rst_release_load", 96'(en), 96'(1));
      run = 1'b0;
      tick(81);
      check("rst_word_count", 96'(wcnt), 96'(1));

      // Word counter rollover from a preloaded 0xFFFF
      force dut.word_count_q = 16'hFFFF;
      tick(1);
      release dut.word_count_q;
      tick(1);
      check("roll_preload", 96'(wcnt), 96'(16'hFFFF));
      preload(16'h00FF);
      run = 1'b1;
      wait_enable("roll");
      run = 1'b0;
      tick(80);
      check("roll_before", 96'(wcnt), 96'(16'hFFFF));
      tick(1);
      check("roll_wrapped", 96'(wcnt), 96'(16'h0000));
      check("roll_busy",    96'(busy), 96'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
